// File: rtl/pattern_scan_arbiter.sv
// rtl/pattern_scan_arbiter.sv - round-robin shared serial "001"/"111" pattern-scan engine
module pattern_scan_arbiter #(
  parameter int W  = 10,
  parameter int CW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [W-1:0]  data0,
  input  logic [W-1:0]  data1,
  output logic          busy,
  output logic          grant_id,
  output logic          done,
  output logic [CW-1:0] cnt_rise,
  output logic [CW-1:0] cnt_ones,
  output logic          serial_o,
  output logic [1:0]    detect_o
);

  localparam int IW = (W > 2) ? $clog2(W) : 2;
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  sr, sr_nx;
  logic [2:0]    hist, hist_nx;
  logic [IW-1:0] idx, idx_nx;
  logic          last, last_nx;
  logic          busy_nx, grant_nx, done_nx, serial_nx;
  logic [CW-1:0] rise_nx, ones_nx;
  logic [1:0]    detect_nx;
  logic          b, win;
  logic [2:0]    h;

  // last starts at 1 so requester 0 wins the first tie after reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sr       <= '0;
      hist     <= '0;
      idx      <= '0;
      last     <= 1'b1;
      busy     <= 1'b0;
      grant_id <= 1'b0;
      done     <= 1'b0;
      cnt_rise <= '0;
      cnt_ones <= '0;
      serial_o <= 1'b0;
      detect_o <= 2'b00;
    end else begin
      state    <= state_nx;
      sr       <= sr_nx;
      hist     <= hist_nx;
      idx      <= idx_nx;
      last     <= last_nx;
      busy     <= busy_nx;
      grant_id <= grant_nx;
      done     <= done_nx;
      cnt_rise <= rise_nx;
      cnt_ones <= ones_nx;
      serial_o <= serial_nx;
      detect_o <= detect_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req != 2'b00) state_nx = SHIFT;
      SHIFT:   if (idx == LAST_IDX) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sr_nx     = sr;
    hist_nx   = hist;
    idx_nx    = idx;
    last_nx   = last;
    busy_nx   = busy;
    grant_nx  = grant_id;
    done_nx   = done;
    rise_nx   = cnt_rise;
    ones_nx   = cnt_ones;
    serial_nx = serial_o;
    detect_nx = detect_o;
    b         = sr[W-1];
    h         = {hist[1:0], sr[W-1]};
    win       = (req == 2'b11) ? ~last : req[1];
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          sr_nx    = win ? data1 : data0;
          hist_nx  = 3'b000;
          idx_nx   = '0;
          rise_nx  = '0;
          ones_nx  = '0;
          busy_nx  = 1'b1;
          grant_nx = win;
          last_nx  = win;
        end
      end
      SHIFT: begin
        hist_nx   = h;
        sr_nx     = sr << 1;
        serial_nx = b;
        idx_nx    = idx + 1'b1;
        if (h == 3'b001) begin
          detect_nx = 2'b10;
          rise_nx   = cnt_rise + 1'b1;
        end else if (h == 3'b111) begin
          detect_nx = 2'b01;
          ones_nx   = cnt_ones + 1'b1;
        end else begin
          detect_nx = 2'b00;
        end
        if (idx == LAST_IDX) done_nx = 1'b1;
      end
      DONE: begin
        done_nx   = 1'b0;
        busy_nx   = 1'b0;
        detect_nx = 2'b00;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// tb/tb_pattern_scan_arbiter.sv - scoreboard bench for pattern_scan_arbiter
module tb_pattern_scan_arbiter;
  localparam int W  = 10;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req   = 2'b00;
  logic [W-1:0]  data0 = '0;
  logic [W-1:0]  data1 = '0;
  logic          busy, grant_id, done, serial_o;
  logic [CW-1:0] cnt_rise, cnt_ones;
  logic [1:0]    detect_o;

  pattern_scan_arbiter #(.W(W), .CW(CW)) dut (
    .clock(clock), .reset(reset), .req(req), .data0(data0), .data1(data1),
    .busy(busy), .grant_id(grant_id), .done(done), .cnt_rise(cnt_rise),
    .cnt_ones(cnt_ones), .serial_o(serial_o), .detect_o(detect_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic           gid;
    int             rise;
    int             ones;
    logic [2*W-1:0] codes;
    int             gap;
  } exp_t;

  exp_t sbq[$];
  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;
  int cyc    = 0;

  // per-bit detector codes, bit 0 (MSB of word) in the top pair
  localparam logic [2*W-1:0] C_MIX  = 20'b10_00_01_00_00_10_00_00_00_10; // 1110011001
  localparam logic [2*W-1:0] C_ONES = 20'b10_00_01_01_01_01_01_01_01_01; // 1111111111
  localparam logic [2*W-1:0] C_ALT  = 20'b00_10_00_00_00_00_00_00_00_00; // 0101010101
  localparam logic [2*W-1:0] C_B1   = 20'b00_00_10_00_01_00_00_00_10_00; // 0011100011
  localparam logic [2*W-1:0] C_B2   = 20'b10_00_00_00_00_00_00_00_00_10; // 1000000001

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic g, input int r, input int o, input logic [2*W-1:0] c, input int gap);
    exp_t e;
    e.gid = g; e.rise = r; e.ones = o; e.codes = c; e.gap = gap;
    sbq.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_grant_id"}, 32'(grant_id), 0);
    check({tag, "_cnt_rise"}, 32'(cnt_rise), 0);
    check({tag, "_cnt_ones"}, 32'(cnt_ones), 0);
    check({tag, "_serial_o"}, 32'(serial_o), 0);
    check({tag, "_detect_o"}, 32'(detect_o), 0);
  endtask

  task automatic wait_dones(input int target, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clock); #1;
      if (n_done >= target) break;
    end
    if (n_done < target) check("done_timeout", 32'(n_done), 32'(target));
  endtask

  task automatic wait_busy();
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clock); #1;
      if (busy) break;
    end
    if (!busy) check("grant_timeout", 32'(busy), 1);
  endtask

  // monitor: collects detect codes per job and pops the scoreboard on done
  logic           seen = 1'b0;
  logic           want_low = 1'b0;
  int             jc = 0;
  int             last_grant = 0;
  int             gap_meas = 0;
  logic [2*W-1:0] got_codes = '0;

  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (want_low) begin
      check("done_width", 32'(done), 0);
      want_low = 1'b0;
    end
    if (reset) begin
      seen = 1'b0;
    end else if (busy) begin
      if (!seen) begin
        seen = 1'b1;
        jc = 0;
        got_codes = '0;
        gap_meas = cyc - last_grant;
        last_grant = cyc;
      end else begin
        jc++;
        if (jc <= W) got_codes[2*(W-jc) +: 2] = detect_o;
      end
      if (done) begin
        n_done++;
        want_low = 1'b1;
        if (sbq.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("grant_id", 32'(grant_id), 32'(e.gid));
          check("cnt_rise", 32'(cnt_rise), 32'(e.rise));
          check("cnt_ones", 32'(cnt_ones), 32'(e.ones));
          check("detect_codes", 32'(got_codes), 32'(e.codes));
          check("done_latency", 32'(jc), 32'(W));
          if (e.gap != 0) check("grant_gap", 32'(gap_meas), 32'(e.gap));
        end
      end
    end else begin
      seen = 1'b0;
    end
  end

  initial begin
    int base;
    repeat (2) @(negedge clock);
    #1 check_all_zero("reset");
    reset = 1'b0;

    data0 = 10'b1110011001; push(1'b0, 3, 1, C_MIX, 0);  req = 2'b01; wait_dones(1, 40); req = 2'b00;
    data1 = 10'b1111111111; push(1'b1, 1, 8, C_ONES, 0); req = 2'b10; wait_dones(2, 40); req = 2'b00;
    data0 = 10'b0000000000; push(1'b0, 0, 0, '0, 0);     req = 2'b01; wait_dones(3, 40); req = 2'b00;
    data0 = 10'b0101010101; push(1'b0, 1, 0, C_ALT, 0);  req = 2'b01; wait_dones(4, 40); req = 2'b00;

    // tie from reset with both held: alternation and 12-cycle grant spacing
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    base  = n_done;
    data0 = 10'b1110011001;
    data1 = 10'b1111111111;
    push(1'b0, 3, 1, C_MIX, 0);
    push(1'b1, 1, 8, C_ONES, 12);
    push(1'b0, 3, 1, C_MIX, 12);
    push(1'b1, 1, 8, C_ONES, 12);
    req = 2'b11;
    wait_dones(base + 4, 80);
    req = 2'b00;

    // async reset four bits into a job: no done, outputs cleared at once
    repeat (3) @(negedge clock);
    data0 = 10'b1110011001;
    req = 2'b01;
    wait_busy();
    repeat (4) @(posedge clock);
    #3 reset = 1'b1;
    #1 check_all_zero("midreset");
    repeat (2) @(negedge clock);
    base = n_done;
    push(1'b0, 3, 1, C_MIX, 0);
    reset = 1'b0;
    wait_dones(base + 1, 40);
    req = 2'b00;

    // back-to-back from requester 0: history must not carry over
    repeat (3) @(negedge clock);
    base  = n_done;
    data0 = 10'b0011100011;
    push(1'b0, 2, 1, C_B1, 0);
    push(1'b0, 2, 0, C_B2, 12);
    req = 2'b01;
    wait_busy();
    data0 = 10'b1000000001;
    wait_dones(base + 2, 60);
    req = 2'b00;

    repeat (5) @(negedge clock);
    check("scoreboard_empty", 32'(sbq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pattern_scan_arbiter.md
# pattern_scan_arbiter

Shared pattern-scan engine that serialises a W-bit word MSB-first through an internal 3-bit history detector. The detector uses the team's serial pattern semantics: "001" flags a rising run (code 2'b10) and "111" flags a ones run (code 2'b01). Two requesters share the engine under round-robin arbitration. Each job returns per-word counts of both patterns with a one-cycle done pulse. The block sits between word-producing clients and the serial pattern-detection datapath, and owns its sequencing.

## Interface
- W, default 10: word length in bits, W ≥ 3.
- CW, default 4: count width; must satisfy 2^CW ≥ W+1.

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  2  request per requester; held high until that requester sees done.
- data0  in  W  word of requester 0; sampled only on its grant edge.
- data1  in  W  word of requester 1; sampled only on its grant edge.
- busy  out  1  job in progress (grant through done cycle).
- grant_id  out  1  requester being served; valid while busy.
- done  out  1  one-cycle pulse; counts valid.
- cnt_rise  out  CW  number of "001" hits in the current or last job.
- cnt_ones  out  CW  number of "111" hits in the current or last job.
- serial_o  out  1  bit shifted into the history on the last edge.
- detect_o  out  2  per-bit detector code: 10 = "001", 01 = "111", 00 = none.

## Operation
- States: IDLE, SHIFT, DONE. All outputs are registered.
- Reset (async, any state, mid-job included):
  - state IDLE; busy, done, grant_id, cnt_rise, cnt_ones, serial_o, detect_o all 0; history 000.
  - Round-robin pointer set so that req[0] wins the first tie.
  - An in-flight job is discarded with no done pulse.
- IDLE, req == 00: hold; counts keep their last values.
- IDLE, req != 00, on the edge:
  - Grant the single requester, or on a tie the one not served last.
  - Load shift register with that requester's data; history ← 000; counts ← 0; bit index ← 0.
  - busy ← 1; grant_id ← winner; update pointer; go to SHIFT.
- SHIFT, each edge:
  - b = sr[W-1]; history ← {history[1:0], b}; sr ← sr << 1; serial_o ← b; index++.
  - Evaluate the new history value:
    - 001: detect_o ← 10, cnt_rise++.
    - 111: detect_o ← 01, cnt_ones++.
    - otherwise: detect_o ← 00.
  - On the edge that shifts bit W-1 (index W-1): done ← 1, go to DONE.
- DONE, next edge: done ← 0; busy ← 0; detect_o ← 00; go to IDLE. Counts hold until the next grant.
- No count overflow is possible, since each count is at most W-2. No saturation logic.
- History is cleared per job. A word starting with 1 therefore produces an immediate "001" hit.
- req changes during SHIFT/DONE are ignored. Arbitration happens only in IDLE.

## Timing
- Grant edge E0: busy = 1 after E0.
- Bit k (k = 0..W-1, MSB first) is shifted at edge E(k+1). serial_o, detect_o and the counts reflect bit k after that edge.
- done is high between E(W) and E(W+1), with the final counts.
- busy falls at E(W+1). The earliest next grant is E(W+2). Throughput is one job per W+2 cycles.
- A requester must drop req before E(W+2); otherwise it is re-served (after the other requester, if it is also requesting).

## Test plan
- Word 1110011001 on data0, req = 01:
  - grant_id = 0.
  - detect_o per bit: 10,00,01,00,00,10,00,00,00,10.
  - At done: cnt_rise = 3, cnt_ones = 1. done high exactly 1 cycle, 10 cycles after grant.
- data1 = 1111111111, req = 10 → cnt_rise = 1, cnt_ones = 8, grant_id = 1.
- data0 = 0000000000 → both counts 0, detect_o all 00. data0 = 0101010101 → cnt_rise = 1, cnt_ones = 0.
- req = 11 from reset with both held:
  - Grants alternate 0, 1, 0, 1.
  - Gap between consecutive grant edges is 12 cycles.
  - Each done is accompanied by the correct grant_id.
- Reset asserted mid-SHIFT (after 4 bits), asynchronously between edges:
  - All outputs 0 immediately; no done pulse.
  - After release with req = 01, a fresh job completes with correct counts.
- Back-to-back jobs from requester 0 with different words: counts clear at each grant, with no carry-over of history. The second word 1xxxxxxxxx still yields an initial 10 code.
